alu_issue_sequencer: RTL
========================

Name: alu_issue_sequencer

Overview:
Buffers 19-bit ALU instructions and issues them one at a time to the combinational ALU control unit.
- Instruction format: opcode [18:16], operands [15:0].
- Captures the 8-bit ALU result into a registered output stage with a valid/ready handshake.
- Sits between the instruction source (testbench or fetch logic) and the result consumer.
- Owns NOP filtering, back-pressure and flush sequencing for the ALU.

Parameters:
DEPTH, 4, instruction FIFO entries; power of 2, minimum 2
PTR_W, 2, log2(DEPTH); must match DEPTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
instr_in  input  19  instruction {opcode[2:0], operands[15:0]}
instr_valid  input  1  instr_in is presented
instr_ready  output  1  FIFO can accept; equals !full, taken from registered state
flush  input  1  synchronous; discards all FIFO entries
alu_instr  output  19  instruction to the ALU; FIFO head when issuing, else 19'b0
alu_result  input  8  combinational ALU result for alu_instr
result_out  output  8  registered result
result_op  output  3  opcode that produced result_out
result_valid  output  1  result_out/result_op are valid
result_ready  input  1  consumer accepts the result
busy  output  1  FIFO non-empty OR result_valid

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, pointers 0, result_out=0, result_op=0, result_valid=0, state IDLE. This holds mid-operation too: pending instructions and any unaccepted result are dropped.
- Push: instr_valid && instr_ready at an edge writes instr_in at the tail.
  - instr_ready is low when full; instr_valid is then ignored, nothing is dropped, and the source must hold.
- Issue condition: `can_issue = !empty && (!result_valid || result_ready)`.
  - When can_issue=1, alu_instr = FIFO head; otherwise alu_instr = 19'b0.
  - At the edge, the head is popped.
  - If the head opcode != 000: result_out<=alu_result, result_op<=opcode, result_valid<=1.
  - If the opcode is 000 (NOP): popped with no result; result_valid<=0 if result_ready, otherwise unchanged.
- Output drain: result_valid && result_ready && !can_issue makes result_valid<=0.
- Output hold: while result_valid && !result_ready, result_out and result_op are held stable.
- Latency: instruction pushed at edge N, result_valid high after edge N+1 (2 cycles), given an empty FIFO and a free output.
- Throughput: one result per cycle with result_ready held high.
- No empty-FIFO bypass: an instruction pushed into an empty FIFO is issued the following cycle.
- Full FIFO with a pop in the same cycle: instr_ready still reads 0 that cycle (registered); no same-cycle push.
- Pointer wrap: modulo DEPTH. Full/empty are distinguished by a count register (PTR_W+1 bits).
- flush=1: FIFO emptied at the edge; no issue that cycle (alu_instr=0).
  - A push in the same cycle is discarded.
  - The output register is unaffected; a pending result still drains normally.
- States:
  - IDLE: empty && !result_valid.
  - RUN: can_issue, or draining.
  - STALL: result_valid && !result_ready && !empty.
  - Transitions are evaluated each edge from the conditions above. The state is informational and must be consistent with busy (busy=0 iff IDLE).

Optional Feature:
Macro: ALU_SEQ_STATS_EN
- Defined:
  - Adds output `issued_cnt [15:0]`: counts non-NOP issues.
  - Adds output `nop_cnt [15:0]`: counts NOP pops.
  - Both clear on rst, wrap 16'hFFFF->0, and are not affected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> result_valid=0, result_out=0, instr_ready=1, busy=0, alu_instr=0.
- Single add: push {3'b001, 8'h05, 8'h03}, result_ready=1, real ALU attached -> result_valid=1 two cycles later, result_out=8'h08, result_op=3'b001; busy clears the next cycle.
- Back-pressure and full:
  - Stimulus: result_ready=0; push 5 non-NOP instructions.
  - Required: the first is issued into the output stage, the next 4 fill the FIFO, then instr_ready=0.
  - Then result_ready=1: 5 results in push order on consecutive cycles, with no loss or duplication.
- NOP filtering: push NOP, add, NOP, NOP, add -> exactly 2 results, in order; with ALU_SEQ_STATS_EN, issued_cnt=2 and nop_cnt=3.
- Flush with pending result: result_ready=0, 1 result pending, 3 queued; pulse flush -> FIFO empty; the pending result remains valid and drains when result_ready=1; no further results.
- Reset mid-stall: STALL with a full FIFO, rst=1 for one cycle -> all state cleared as at reset; the next pushed instruction yields its result after 2 cycles.

Source files
------------

// File: rtl/alu_issue_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_issue_sequencer_if
// Bundles the instruction push port, the ALU issue/return path and the
// result handshake of the ALU issue sequencer.
//   slave  : seen by the sequencer
//   master : seen by the instruction source / ALU / result consumer side
// ---------------------------------------------------------------------------
interface alu_issue_sequencer_if;
   logic [18:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic        flush;
   logic [18:0] alu_instr;
   logic [7:0]  alu_result;
   logic [7:0]  result_out;
   logic [2:0]  result_op;
   logic        result_valid;
   logic        result_ready;
   logic        busy;

   modport slave (
      input  instr_in, instr_valid, flush, alu_result, result_ready,
      output instr_ready, alu_instr, result_out, result_op, result_valid, busy
   );

   modport master (
      output instr_in, instr_valid, flush, alu_result, result_ready,
      input  instr_ready, alu_instr, result_out, result_op, result_valid, busy
   );
endinterface

// File: rtl/alu_issue_sequencer.sv
// ---------------------------------------------------------------------------
// alu_issue_sequencer
// Queues 19-bit ALU instructions {opcode[2:0], operands[15:0]} in a small
// FIFO, issues the head to the combinational ALU control unit one at a time,
// filters NOPs (opcode 000) and captures non-NOP results into a registered
// valid/ready output stage. Flush empties the queue without touching the
// output stage.
// Optional build macro: ALU_SEQ_STATS_EN adds issued_cnt / nop_cnt counters.
// ---------------------------------------------------------------------------
module alu_issue_sequencer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef ALU_SEQ_STATS_EN
   output logic [15:0]            issued_cnt,
   output logic [15:0]            nop_cnt,
`endif
   alu_issue_sequencer_if.slave   bus
);

   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W+1)'(0);
   localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } seq_state_t;

   // FIFO storage and bookkeeping
   logic [18:0]      mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;

   // output stage
   logic [7:0]       result_out_r;
   logic [2:0]       result_op_r;
   logic             result_valid_r;

   seq_state_t       state_r;
   seq_state_t       state_nxt_s;

   logic             empty_s;
   logic             full_s;
   logic             push_s;
   logic             can_issue_s;
   logic [18:0]      head_s;
   logic [2:0]       head_op_s;

   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [PTR_W:0]   count_nxt_s;
   logic [7:0]       result_out_nxt_s;
   logic [2:0]       result_op_nxt_s;
   logic             result_valid_nxt_s;

   assign empty_s   = (count_r == CNT_ZERO);
   assign full_s    = (count_r == CNT_DEPTH);
   assign head_s    = mem_r[rd_ptr_r];
   assign head_op_s = head_s[18:16];

   // flush blocks both the push and the issue in its cycle
   assign push_s      = bus.instr_valid && !full_s && !bus.flush;
   assign can_issue_s = !empty_s && (!result_valid_r || bus.result_ready) && !bus.flush;

   assign bus.instr_ready  = !full_s;
   assign bus.alu_instr    = can_issue_s ? head_s : 19'd0;
   assign bus.result_out   = result_out_r;
   assign bus.result_op    = result_op_r;
   assign bus.result_valid = result_valid_r;
   assign bus.busy         = (state_r != ST_IDLE);

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      count_nxt_s  = count_r;
      if (bus.flush) begin
         wr_ptr_nxt_s = {PTR_W{1'b0}};
         rd_ptr_nxt_s = {PTR_W{1'b0}};
         count_nxt_s  = CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (can_issue_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         if (push_s && !can_issue_s) begin
            count_nxt_s = count_r + CNT_ONE;
         end else if (!push_s && can_issue_s) begin
            count_nxt_s = count_r - CNT_ONE;
         end else begin
            count_nxt_s = count_r;
         end
      end
   end

   // output stage next-state: load on non-NOP issue, drop valid when consumed
   always_comb begin
      result_out_nxt_s   = result_out_r;
      result_op_nxt_s    = result_op_r;
      result_valid_nxt_s = result_valid_r;
      if (can_issue_s) begin
         if (head_op_s != 3'b000) begin
            result_out_nxt_s   = bus.alu_result;
            result_op_nxt_s    = head_op_s;
            result_valid_nxt_s = 1'b1;
         end else if (bus.result_ready) begin
            result_valid_nxt_s = 1'b0;
         end else begin
            result_valid_nxt_s = result_valid_r;
         end
      end else if (result_valid_r && bus.result_ready) begin
         result_valid_nxt_s = 1'b0;
      end else begin
         result_valid_nxt_s = result_valid_r;
      end
   end

   // sequencer state classification from the upcoming queue/output contents
   always_comb begin
      state_nxt_s = ST_RUN;
      if ((count_nxt_s == CNT_ZERO) && !result_valid_nxt_s) begin
         state_nxt_s = ST_IDLE;
      end else if (result_valid_nxt_s && !bus.result_ready && (count_nxt_s != CNT_ZERO)) begin
         state_nxt_s = ST_STALL;
      end else begin
         state_nxt_s = ST_RUN;
      end
   end

   // FIFO entry write on accepted push
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 19'd0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= bus.instr_in;
      end
   end

   // FIFO pointers, output stage and state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r       <= {PTR_W{1'b0}};
         rd_ptr_r       <= {PTR_W{1'b0}};
         count_r        <= CNT_ZERO;
         result_out_r   <= 8'd0;
         result_op_r    <= 3'd0;
         result_valid_r <= 1'b0;
         state_r        <= ST_IDLE;
      end else begin
         wr_ptr_r       <= wr_ptr_nxt_s;
         rd_ptr_r       <= rd_ptr_nxt_s;
         count_r        <= count_nxt_s;
         result_out_r   <= result_out_nxt_s;
         result_op_r    <= result_op_nxt_s;
         result_valid_r <= result_valid_nxt_s;
         state_r        <= state_nxt_s;
      end
   end

`ifdef ALU_SEQ_STATS_EN
   // issue statistics; flush never issues so it needs no special handling
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt <= 16'd0;
         nop_cnt    <= 16'd0;
      end else if (can_issue_s) begin
         if (head_op_s != 3'b000) begin
            issued_cnt <= issued_cnt + 16'd1;
         end else begin
            nop_cnt    <= nop_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
